// File: rtl/gf2_pkg.sv
// Shared types and parameters for the GF(2)[x] product reducer.
package gf2_pkg;

    localparam int M_DEFAULT = 384;
    localparam logic [M_DEFAULT-1:0] POLY_DEFAULT = 384'h100B;

    // Fold cycles needed to clear product bits 2M-2 down to M.
    function automatic int nfold(input int m, input int fold);
        return (m - 1 + fold - 1) / fold;
    endfunction

    typedef enum logic [1:0] {IDLE, REDUCE, DONE} state_t;

endpackage

// File: rtl/gf2_fold_step.sv
// One combinational fold cycle: clears up to FOLD product bits from index top downward.
module gf2_fold_step
    import gf2_pkg::*;
#(
    parameter int M = M_DEFAULT,
    parameter int FOLD = 8,
    parameter logic [M-1:0] POLY = POLY_DEFAULT
) (
    input  logic [2*M-1:0]         acc,
    input  logic [$clog2(2*M)-1:0] top,
    output logic [2*M-1:0]         acc_nxt
);

    localparam int W  = 2 * M;
    localparam int IW = $clog2(W);
    localparam logic [W-1:0] POLY_EXT = W'(POLY);

    // Each stage feeds the next, so a fold that lands on a lower bit in this window is seen.
    for (genvar j = 0; j < FOLD; j++) begin : g_bit
        logic [W-1:0]  prv;
        logic [W-1:0]  nxt;
        logic [IW-1:0] idx;
        logic          hit;

        if (j == 0) begin : g_head
            assign prv = acc;
        end else begin : g_link
            assign prv = g_bit[j-1].nxt;
        end

        assign idx = top - IW'(j);
        assign hit = (top >= IW'(M + j)) && prv[idx];
        assign nxt = hit ? ((prv ^ (POLY_EXT << (idx - IW'(M)))) & ~(W'(1) << idx)) : prv;
    end

    assign acc_nxt = g_bit[FOLD-1].nxt;

endmodule

// File: rtl/gf2_poly_reducer.sv
// Multi-cycle reducer of a 2M-bit carry-less product modulo x^M + POLY, FOLD bits per cycle.
module gf2_poly_reducer
    import gf2_pkg::*;
#(
    parameter int M = M_DEFAULT,
    parameter int FOLD = 8,
    parameter logic [M-1:0] POLY = POLY_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*M-1:0] in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [M-1:0]   out_data
);

    localparam int NFOLD = nfold(M, FOLD);
    localparam int CW    = $clog2(NFOLD + 1);
    localparam int IW    = $clog2(2 * M);

    state_t          state;
    logic [2*M-1:0]  acc;
    logic [2*M-1:0]  acc_fold;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   top;

    assign top = IW'(2 * M - 2) - IW'(cnt) * IW'(FOLD);

    gf2_fold_step #(.M(M), .FOLD(FOLD), .POLY(POLY)) u_fold (
        .acc     (acc),
        .top     (top),
        .acc_nxt (acc_fold)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    // Bit 2M-1 can never be set in a real product; drop it.
                    acc      <= {1'b0, in_data[2*M-2:0]};
                    cnt      <= '0;
                    state    <= REDUCE;
                    in_ready <= 1'b0;
                end
                REDUCE: begin
                    acc <= acc_fold;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(NFOLD - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_data  <= acc_fold[M-1:0];
                    end
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gf2_poly_reducer.sv
// Directed and randomized checks of gf2_poly_reducer at FOLD = 1, 8 and 7 against a long-division model.
module tb_gf2_poly_reducer;

    localparam int M = 384;
    localparam int W = 2 * M;
    localparam logic [M-1:0] POLY = 384'h100B;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic [W-1:0]   in_data;
    logic [2:0]     ordy;
    logic [2:0]     irdy;
    logic [2:0]     ov;
    logic [M-1:0]   od [3];

    int total = 0;
    int bad   = 0;

    gf2_poly_reducer #(.M(M), .FOLD(1), .POLY(POLY)) u_f1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy[0]), .in_data(in_data),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]));
    gf2_poly_reducer #(.M(M), .FOLD(8), .POLY(POLY)) u_f8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy[1]), .in_data(in_data),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]));
    gf2_poly_reducer #(.M(M), .FOLD(7), .POLY(POLY)) u_f7 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy[2]), .in_data(in_data),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Polynomial long division over GF(2): remainder of c / (x^M + POLY).
    function automatic logic [M-1:0] ref_mod(input logic [W-1:0] c);
        logic [W-1:0] r;
        logic [W-1:0] f;
        r = c;
        r[W-1] = 1'b0;
        for (int d = W - 2; d >= M; d--) begin
            if (r[d]) begin
                f = W'(POLY);
                f[M] = 1'b1;
                r = r ^ (f << (d - M));
            end
        end
        return r[M-1:0];
    endfunction

    function automatic logic [W-1:0] rnd_wide();
        logic [W-1:0] v;
        for (int k = 0; k < W / 32; k++) v[k*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic chk(input string tag, input logic [M-1:0] obs, input logic [M-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Present one product to the FOLD=8 instance; returns at the negedge after the accept edge.
    task automatic send(input logic [W-1:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (!irdy[1] && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", M'(irdy[1]), M'(1));
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat, output logic rdy_seen);
        lat = 0;
        rdy_seen = 1'b0;
        while (!ov[1] && lat < 1000) begin
            @(negedge clk);
            lat++;
            rdy_seen = rdy_seen | irdy[1];
        end
    endtask

    task automatic take();
        ordy[1] = 1'b1;
        @(negedge clk);
        ordy[1] = 1'b0;
    endtask

    initial begin
        logic [W-1:0] d;
        logic [M-1:0] e;
        logic [2:0]   done;
        logic         seen;
        int           lat;
        int           cyc;
        int           r;

        rst = 1'b0; in_valid = 1'b0; in_data = '0; ordy = 3'b101;
        #2 rst = 1'b1;
        #2;
        chk("rst_out_valid", M'(ov), M'(0));
        chk("rst_out_data", od[1], '0);
        chk("rst_in_ready", M'(irdy), M'(3'b111));
        @(negedge clk);
        rst = 1'b0;

        // Zero product: timing and in_ready low while busy.
        send('0);
        wait_out(lat, seen);
        chk("lat_zero", M'(lat), M'(48));
        chk("busy_in_ready", M'(seen), M'(0));
        chk("zero_data", od[1], '0);
        take();

        d = '0; d[384] = 1'b1;
        send(d);
        wait_out(lat, seen);
        chk("x384", od[1], POLY);
        take();

        d = '0; d[766] = 1'b1;
        e = '0;
        e[383] = 1'b1; e[382] = 1'b1; e[22] = 1'b1; e[11] = 1'b1;
        e[10] = 1'b1; e[4] = 1'b1; e[2] = 1'b1; e[1] = 1'b1;
        send(d);
        wait_out(lat, seen);
        chk("x766", od[1], e);
        take();

        // Already reduced; the never-valid top bit is set to show it is ignored.
        d = rnd_wide();
        d[W-2:M] = '0;
        d[W-1] = 1'b1;
        send(d);
        wait_out(lat, seen);
        chk("passthru", od[1], d[M-1:0]);
        take();

        // Consumer stall: result must hold and no new accept.
        d = rnd_wide();
        e = ref_mod(d);
        send(d);
        wait_out(lat, seen);
        for (int k = 0; k < 20; k++) begin
            chk("stall_valid", M'(ov[1]), M'(1));
            chk("stall_data", od[1], e);
            chk("stall_in_ready", M'(irdy[1]), M'(0));
            @(negedge clk);
        end
        take();
        chk("post_in_ready", M'(irdy[1]), M'(1));
        chk("post_out_valid", M'(ov[1]), M'(0));
        chk("post_data_kept", od[1], e);

        // Abort mid-reduction.
        send(rnd_wide());
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_out_valid", M'(ov), M'(0));
        chk("abort_out_data", od[1], '0);
        chk("abort_in_ready", M'(irdy), M'(3'b111));
        @(negedge clk);
        rst = 1'b0;
        d = rnd_wide();
        send(d);
        wait_out(lat, seen);
        chk("abort_lat", M'(lat), M'(48));
        chk("abort_data", od[1], ref_mod(d));
        take();

        // Randomized: all three fold widths, random consumer stalls.
        cyc = 0;
        while (irdy != 3'b111 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        chk("rand_idle", M'(irdy), M'(3'b111));
        for (int t = 0; t < 8; t++) begin
            d = rnd_wide();
            e = ref_mod(d);
            in_valid = 1'b1;
            in_data  = d;
            @(negedge clk);
            in_valid = 1'b0;
            done = 3'b000;
            cyc = 0;
            while (done != 3'b111 && cyc < 3000) begin
                @(negedge clk);
                cyc++;
                for (int k = 0; k < 3; k++) begin
                    r = $urandom_range(0, 1);
                    if (!done[k] && ov[k] && r == 1) begin
                        chk($sformatf("rand_f%0d", k), od[k], e);
                        done[k] = 1'b1;
                    end
                    ordy[k] = (r == 1);
                end
            end
            chk("rand_complete", M'(done), M'(3'b111));
            @(negedge clk);
            ordy = 3'b000;
            chk("rand_back_idle", M'(irdy), M'(3'b111));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
